// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 datapath mux.
// Grants last until a final beat, quantum expiry or request withdrawal.
module mux4 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned QUANTUM = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             y_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             y_valid,
    output logic [WIDTH-1:0] y
);
    localparam int unsigned CW = $clog2(QUANTUM + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(QUANTUM - 1);

    typedef enum logic {IDLE, GRANT} st_t;

    st_t           st_q, st_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    win;
    logic          found;
    logic          xfer;

    mux4 #(.WIDTH(WIDTH)) u_mux (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .s  (sel_q),
        .y  (y)
    );

    assign y_valid = (st_q == GRANT) & req[sel_q];
    assign xfer    = y_valid & y_ready;
    assign gnt     = gnt_q;
    assign sel     = sel_q;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && req[ptr_q + 2'(i)]) begin
                win   = ptr_q + 2'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        st_d  = st_q;
        ptr_d = ptr_q;
        sel_d = sel_q;
        gnt_d = gnt_q;
        cnt_d = cnt_q;
        case (st_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    sel_d = win;
                    gnt_d = 4'b0001 << win;
                    cnt_d = '0;
                    st_d  = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel_q] || (xfer && (last[sel_q] || cnt_q == CNT_LAST))) begin
                    st_d  = IDLE;
                    gnt_d = '0;
                    cnt_d = '0;
                    ptr_d = sel_q + 2'd1;
                end else if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q  <= IDLE;
            ptr_q <= '0;
            sel_q <= '0;
            gnt_q <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            ptr_q <= ptr_d;
            sel_q <= sel_d;
            gnt_q <= gnt_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized checks of mux4_rr_arbiter against a beat-counting
// reference model of the round-robin grant rules.
module tb_mux4_rr_arbiter;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned QUANTUM = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req, last;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic             y_ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             y_valid;
    logic [WIDTH-1:0] y;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the mux, where the search starts, beats sent.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_beats;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .QUANTUM(QUANTUM)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .last    (last),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .y_ready (y_ready),
        .gnt     (gnt),
        .sel     (sel),
        .y_valid (y_valid),
        .y       (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] dsel(input int i);
        case (i)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    task automatic model_release();
        m_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % 4;
        m_beats = 0;
    endtask

    task automatic model_update();
        if (!reset) begin
            m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_beats = 0;
        end else if (!m_busy) begin
            if (req != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (req[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_beats = 0;
            end
        end else if (!req[m_owner]) begin
            model_release();
        end else if (y_ready) begin
            m_beats++;
            if (last[m_owner] || m_beats == QUANTUM) model_release();
        end
    endtask

    // Check outputs mid-cycle, then advance one edge and the model with it.
    task automatic tick(input int n = 1);
        for (int c = 0; c < n; c++) begin
            #1;
            chk("gnt", 64'(gnt), m_busy ? 64'(4'b0001 << m_owner) : 64'd0);
            chk("sel", 64'(sel), 64'(m_owner));
            chk("y_valid", 64'(y_valid), 64'(m_busy && req[m_owner]));
            chk("y", 64'(y), 64'(dsel(m_owner)));
            @(posedge clk);
            model_update();
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        req = r; last = l; y_ready = rdy;
    endtask

    initial begin
        reset = 1'b0;
        drive(4'b1111, 4'b1111, 1'b1);
        d0 = 8'h10; d1 = 8'h21; d2 = 8'h03; d3 = 8'h43;
        @(posedge clk);
        model_update();
        #1;

        // Reset held with all requests pending, then first grant to 0.
        tick(2);
        reset = 1'b1;
        tick(3);

        // Single requester with a one-beat packet.
        reset = 1'b0; tick(1); reset = 1'b1;
        drive(4'b0100, 4'b0100, 1'b1);
        tick(4);
        drive(4'b1111, 4'b1111, 1'b1);
        tick(2);

        // Rotation with single-beat grants.
        tick(12);

        // Quantum expiry.
        reset = 1'b0; tick(1); reset = 1'b1;
        drive(4'b0011, 4'b0000, 1'b1);
        tick(14);

        // Backpressure during a grant to requester 1.
        reset = 1'b0; tick(1); reset = 1'b1;
        drive(4'b0010, 4'b0000, 1'b1);
        tick(2);
        y_ready = 1'b0; tick(3);
        y_ready = 1'b1; tick(4);

        // Withdrawal mid-grant.
        reset = 1'b0; tick(1); reset = 1'b1;
        drive(4'b0100, 4'b0000, 1'b1);
        tick(3);
        req = 4'b0000; tick(2);
        drive(4'b1111, 4'b0000, 1'b1);
        tick(2);

        // Reset mid-grant.
        drive(4'b0100, 4'b0000, 1'b0);
        tick(3);
        reset = 1'b0; tick(1); reset = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1);
        tick(3);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            last    = 4'($urandom) & 4'($urandom);
            y_ready = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 60) != 0);
            d0 = 8'($urandom); d1 = 8'($urandom);
            d2 = 8'($urandom); d3 = 8'($urandom);
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
